// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encodings, FSM state type and default widths shared by the SPI/host RAM arbiter.
package spi_ram_pkg;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_MEM_WIDTH = 8;
  localparam int RX_WIDTH      = 10;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE_SPI  = 2'd1,
    ISSUE_HOST = 2'd2,
    RD_WAIT    = 2'd3
  } state_e;
  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_SPI  = 1'b1
  } src_e;
  function automatic logic is_access(cmd_e c);
    return (c == CMD_WR_DATA) || (c == CMD_RD_DATA);
  endfunction
endpackage

// File: rtl/spi_cmd_slot.sv
// spi_cmd_slot: decodes SPI words, keeps the write/read address registers and
// the one-entry pending RAM command slot (overwrite on collision, flagged by ovf).
module spi_cmd_slot
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RX_WIDTH-1:0]  rx_data,
  input  logic                 rx_valid,
  input  logic                 take,
  output logic                 pend_valid,
  output logic                 pend_we,
  output logic [ADDR_SIZE-1:0] pend_addr,
  output logic [MEM_WIDTH-1:0] pend_data,
  output logic                 ovf
);
  cmd_e                 cmd;
  logic                 acc;
  logic [ADDR_SIZE-1:0] pay_addr;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [MEM_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                 pend_v_q, pend_v_d, pend_we_q, pend_we_d, ovf_q, ovf_d;
  always_comb begin
    cmd         = cmd_e'(rx_data[9:8]);
    pay_addr    = ADDR_SIZE'(rx_data[7:0]);
    acc         = rx_valid && is_access(cmd);
    wr_addr_d   = (rx_valid && cmd == CMD_WR_ADDR) ? pay_addr : wr_addr_q;
    rd_addr_d   = (rx_valid && cmd == CMD_RD_ADDR) ? pay_addr : rd_addr_q;
    pend_v_d    = acc || (pend_v_q && !take);
    pend_we_d   = acc ? (cmd == CMD_WR_DATA) : pend_we_q;
    pend_addr_d = acc ? ((cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q) : pend_addr_q;
    pend_data_d = acc ? MEM_WIDTH'(rx_data[7:0]) : pend_data_q;
    // a refill in the same edge the arbiter drains the slot is not an overflow
    ovf_d       = acc && pend_v_q && !take;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_v_q    <= 1'b0;
      pend_we_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_v_q    <= pend_v_d;
      pend_we_q   <= pend_we_d;
      ovf_q       <= ovf_d;
    end
  end
  assign pend_valid = pend_v_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;
  assign ovf        = ovf_q;
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port RAM between an SPI command stream and a host port.
// Define ARB_SPI_PRIORITY_EN to make SPI win every tie; otherwise ties are round robin.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RX_WIDTH-1:0]  rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 spi_ovf
);
  state_e               state_q;
  src_e                 src_q, last_q;
  logic                 ram_en_q, ram_we_q, host_gnt_q, host_rvalid_q, tx_valid_q;
  logic [ADDR_SIZE-1:0] ram_addr_q;
  logic [MEM_WIDTH-1:0] ram_wdata_q, host_rdata_q, tx_data_q;
  logic                 pend_valid, pend_we, spi_tie, go_spi, go_host;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [MEM_WIDTH-1:0] pend_data;
  spi_cmd_slot #(.ADDR_SIZE(ADDR_SIZE), .MEM_WIDTH(MEM_WIDTH)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .take      (go_spi),
    .pend_valid(pend_valid),
    .pend_we   (pend_we),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .ovf       (spi_ovf)
  );
  always_comb begin
`ifdef ARB_SPI_PRIORITY_EN
    spi_tie = 1'b1;
`else
    spi_tie = (last_q == SRC_HOST);
`endif
    go_spi  = (state_q == IDLE) && pend_valid && (!host_req || spi_tie);
    go_host = (state_q == IDLE) && host_req && !go_spi;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      src_q         <= SRC_HOST;
      last_q        <= SRC_HOST;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      if (rx_valid) tx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_spi) begin
            state_q     <= ISSUE_SPI;
            src_q       <= SRC_SPI;
            last_q      <= SRC_SPI;
            ram_en_q    <= 1'b1;
            ram_we_q    <= pend_we;
            ram_addr_q  <= pend_addr;
            ram_wdata_q <= pend_we ? pend_data : '0;
          end else if (go_host) begin
            state_q     <= ISSUE_HOST;
            src_q       <= SRC_HOST;
            last_q      <= SRC_HOST;
            ram_en_q    <= 1'b1;
            ram_we_q    <= host_we;
            ram_addr_q  <= host_addr;
            ram_wdata_q <= host_we ? host_wdata : '0;
            host_gnt_q  <= 1'b1;
          end
        end
        ISSUE_SPI, ISSUE_HOST: state_q <= ram_we_q ? IDLE : RD_WAIT;
        RD_WAIT: begin
          state_q <= IDLE;
          if (src_q == SRC_HOST) begin
            host_rdata_q  <= ram_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            tx_data_q  <= ram_rdata;
            tx_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign host_gnt    = host_gnt_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: randomized self-checking bench; a word-level memory model
// predicts RAM contents, read-back values and arbitration order.
module tb_spi_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovf;
  logic       load = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  int total = 0;
  int bad = 0;

  spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  // single-port RAM with one-cycle read latency, preloaded from the model image
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= exp_mem[i];
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] w);
    rx_data = w;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 8 && tx_valid !== 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, spi_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {ram_en, ram_we, ram_addr, ram_wdata, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, spi_ovf});
    end
    tick();
    tick();
    load = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_basic();
    send({2'b00, 8'h12});
    send({2'b01, 8'hA5});
    exp_mem[8'h12] = 8'hA5;
    tick();
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h12, 8'hA5}) begin
      bad++;
      $display("FAIL spi_write_strobe got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'h12, 8'hA5});
    end
    tick();
    send({2'b10, 8'h12});
    send({2'b11, 8'h00});
    for (int e = 1; e <= 3; e++) begin
      total++;
      if (tx_valid !== 1'b0) begin
        bad++;
        $display("FAIL tx_early edge=%0d got=%b exp=0", e, tx_valid);
      end
      tick();
    end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== exp_mem[8'h12]) begin
      bad++;
      $display("FAIL tx_third_edge got=%b/%h exp=1/%h", tx_valid, tx_data, exp_mem[8'h12]);
    end
  endtask

  task automatic test_spi_random();
    logic [7:0] a, d, b;
    for (int n = 0; n < 8; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      send({2'b00, a});
      send({2'b01, d});
      exp_mem[a] = d;
      tick();
      tick();
      b = n[0] ? a : 8'($urandom);
      send({2'b10, b});
      send({2'b11, 8'($urandom)});
      wait_tx();
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_mem[b]) begin
        bad++;
        $display("FAIL spi_rand_read addr=%h got=%b/%h exp=1/%h", b, tx_valid, tx_data, exp_mem[b]);
      end
    end
  endtask

  task automatic test_arb_tie();
    test_reset();
    send({2'b00, 8'h33});
    rx_data = {2'b01, 8'h5C};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 8'h40;
    exp_mem[8'h33] = 8'h5C;
    tick();
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, host_gnt} !== {1'b1, 1'b1, 8'h33, 8'h5C, 1'b0}) begin
      bad++;
      $display("FAIL tie_spi_first got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata, host_gnt}, {1'b1, 1'b1, 8'h33, 8'h5C, 1'b0});
    end
    tick();
    tick();
    total++;
    if ({host_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h40}) begin
      bad++;
      $display("FAIL tie_host_second got=%h exp=%h", {host_gnt, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 8'h40});
    end
    host_req = 1'b0;
    tick();
    tick();
    total++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp_mem[8'h40]) begin
      bad++;
      $display("FAIL tie_host_rdata got=%b/%h exp=1/%h", host_rvalid, host_rdata, exp_mem[8'h40]);
    end
  endtask

  task automatic test_round_robin();
    bit last_spi = 1'b0;
    bit exp_host;
    test_reset();
    send({2'b00, 8'hFE});
    rx_data = {2'b01, 8'h66};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'hFF;
    host_wdata = 8'h77;
    for (int c = 0; c < 24; c++) begin
      tick();
      rx_valid = 1'b0;
      if (ram_en === 1'b1) begin
`ifdef ARB_SPI_PRIORITY_EN
        exp_host = 1'b0;
`else
        exp_host = last_spi;
`endif
        total++;
        if (host_gnt !== exp_host || spi_ovf !== 1'b0) begin
          bad++;
          $display("FAIL rr_grant cycle=%0d got=%b/%b exp=%b/0", c, host_gnt, spi_ovf, exp_host);
        end
        last_spi = !exp_host;
        if (!exp_host) begin
          rx_data = {2'b01, 8'h66};
          rx_valid = 1'b1;
        end
      end
    end
    rx_valid = 1'b0;
    host_req = 1'b0;
    exp_mem[8'hFE] = 8'h66;
`ifndef ARB_SPI_PRIORITY_EN
    exp_mem[8'hFF] = 8'h77;
`endif
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_overflow();
    send({2'b00, 8'hAA});
    host_we = 1'b0;
    host_addr = 8'h10;
    host_req = 1'b1;
    tick();
    total++;
    if (host_gnt !== 1'b1) begin
      bad++;
      $display("FAIL ovf_host_gnt got=%b exp=1", host_gnt);
    end
    host_req = 1'b0;
    send({2'b01, 8'h11});
    send({2'b01, 8'h22});
    total++;
    if (spi_ovf !== 1'b1 || host_rvalid !== 1'b1 || host_rdata !== exp_mem[8'h10]) begin
      bad++;
      $display("FAIL ovf_pulse got=%b/%b/%h exp=1/1/%h", spi_ovf, host_rvalid, host_rdata, exp_mem[8'h10]);
    end
    exp_mem[8'hAA] = 8'h22;
    tick();
    total++;
    if ({spi_ovf, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b0, 1'b1, 1'b1, 8'hAA, 8'h22}) begin
      bad++;
      $display("FAIL ovf_second_payload got=%h exp=%h", {spi_ovf, ram_en, ram_we, ram_addr, ram_wdata}, {1'b0, 1'b1, 1'b1, 8'hAA, 8'h22});
    end
    tick();
    send({2'b10, 8'hAA});
    send({2'b11, 8'h00});
    wait_tx();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      bad++;
      $display("FAIL ovf_readback got=%b/%h exp=1/22", tx_valid, tx_data);
    end
  endtask

  task automatic test_reset_mid();
    host_we = 1'b0;
    host_addr = 8'h20;
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, spi_ovf} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {ram_en, ram_we, ram_addr, ram_wdata, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, spi_ovf});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (host_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_rvalid got=%b exp=0", host_rvalid);
      end
    end
    rst_n = 1'b1;
    tick();
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 6 && host_rvalid !== 1'b1; i++) tick();
    total++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp_mem[8'h20]) begin
      bad++;
      $display("FAIL post_reset_read got=%b/%h exp=1/%h", host_rvalid, host_rdata, exp_mem[8'h20]);
    end
    tick();
  endtask

  task automatic test_tx_hold();
    logic [7:0] a;
    a = 8'($urandom);
    send({2'b10, a});
    send({2'b11, 8'h00});
    wait_tx();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_mem[a]) begin
        bad++;
        $display("FAIL tx_hold cycle=%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_mem[a]);
      end
      tick();
    end
    send({2'b00, 8'h01});
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_clear got=%b exp=0", tx_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
    test_reset();
    test_spi_basic();
    test_spi_random();
    test_arb_tie();
    test_round_robin();
    test_overflow();
    test_reset_mid();
    test_tx_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_SIZE, 8, RAM address width.
REQ-002 SHALL have parameter: MEM_WIDTH, 8, RAM data width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: rx_data  in  10  SPI word; [9:8] command, [7:0] payload.
REQ-007 SHALL have port: rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have port: tx_data  out  MEM_WIDTH  SPI read-back data.
REQ-009 SHALL have port: tx_valid  out  1  tx_data valid, level.
REQ-010 SHALL have port: host_req  in  1  host access request, held until grant.
REQ-011 SHALL have port: host_we  in  1  1 = write, 0 = read.
REQ-012 SHALL have port: host_addr  in  ADDR_SIZE  host address.
REQ-013 SHALL have port: host_wdata  in  MEM_WIDTH  host write data.
REQ-014 SHALL have port: host_gnt  out  1  one-cycle pulse, request accepted.
REQ-015 SHALL have port: host_rdata  out  MEM_WIDTH  host read data.
REQ-016 SHALL have port: host_rvalid  out  1  one-cycle pulse, host_rdata valid.
REQ-017 SHALL have port: ram_en, ram_we  out  1 each  single-port RAM strobes.
REQ-018 SHALL have port: ram_addr  out  ADDR_SIZE; ram_wdata  out  MEM_WIDTH; ram_rdata  in  MEM_WIDTH (valid one cycle after a read strobe).
REQ-019 SHALL have port: spi_ovf  out  1  one-cycle pulse, pending SPI command overwritten.

Function
REQ-020 SHALL decode rx_data[9:8] when rx_valid is high: 00 latch wr_addr, 01 write payload at wr_addr, 10 latch rd_addr, 11 read at rd_addr (payload ignored).
REQ-021 SHALL complete commands 00 and 10 in the sampling cycle, with no RAM access.
REQ-022 SHALL place commands 01 and 11 in a one-entry pending slot; rx_valid arriving while the slot is full SHALL overwrite the slot and pulse spi_ovf.
REQ-023 SHALL use FSM states IDLE, ISSUE_SPI, ISSUE_HOST and RD_WAIT; IDLE goes to ISSUE_x on a request; ISSUE_x goes to RD_WAIT for a read, otherwise to IDLE; RD_WAIT goes to IDLE.
REQ-024 SHALL drive ram_en=1 only in ISSUE_x, with ram_we, ram_addr and ram_wdata taken from the granted source; all ram_* outputs SHALL be 0 otherwise.
REQ-025 SHALL, in IDLE with both sources requesting, grant the source not granted last (round robin).
REQ-026 SHALL pulse host_gnt in the cycle the FSM is in ISSUE_HOST.
REQ-027 SHALL, for an uncontended SPI read, set tx_valid at the 3rd rising edge after the rx_valid sampling edge.
REQ-028 SHALL hold tx_valid and tx_data stable until the next rx_valid is sampled, then clear tx_valid in that same edge.
REQ-029 SHALL register host_rdata from ram_rdata and pulse host_rvalid on the edge leaving RD_WAIT.
REQ-030 SHALL clear the pending slot on the edge entering ISSUE_SPI; a new rx_valid in that same edge SHALL refill the slot without pulsing spi_ovf.
REQ-031 SHALL allow addresses to wrap at 2^ADDR_SIZE-1 with no special handling.

Reset
REQ-032 SHALL, on rst_n low at any time including mid-access, immediately set: state IDLE, pending slot empty, wr_addr=rd_addr=0, last-grant=host, all outputs 0.

Configuration
REQ-033 SHALL, when ARB_SPI_PRIORITY_EN is defined, always grant SPI on a tie; when it is undefined, SHALL use round robin per REQ-025.

Structure
REQ-034 SHALL take command encodings, FSM state type and default widths from a shared package spi_ram_pkg.
REQ-035 SHALL implement command decoding, address registers and the pending slot in sub-module spi_cmd_slot.

Verification
REQ-036 SHALL test: rx 0x012, then rx 0x1A5 -> ram write addr 0x12 data 0xA5; rx 0x212, then rx 0x300 -> tx_data=0xA5, tx_valid set 3 edges later.
REQ-037 SHALL test: SPI write pending with host_req read 0x40 in the same cycle -> SPI first (reset last-grant=host), host_gnt next IDLE, host_rvalid with RAM content.
REQ-038 SHALL test: continuous host_req plus repeated SPI writes -> grants alternate under round robin; SPI always wins with ARB_SPI_PRIORITY_EN.
REQ-039 SHALL test: two rx_valid 0x1xx strobes before the slot drains -> spi_ovf pulse, only the second payload written.
REQ-040 SHALL test: rst_n low during RD_WAIT -> all outputs 0, no host_rvalid; next access runs normally.
REQ-041 SHALL test: tx_valid held across 8+ cycles, cleared on the next rx_valid.
